reg_file_param: RTL and testbench

Parametrised successor to the CPU's 8x8 register file. It provides DEPTH words of DATA_W bits, two asynchronous read ports, one synchronous write port, an optional hardwired zero register and optional write-to-read bypass. A handshaked dump engine streams every register to a testbench or debug sink, replacing $monitor-based inspection. It sits between the instruction decoder/ALU and the writeback mux in the single-cycle datapath.

---
 rtl/reg_file_param.sv | 150 +++++++++++++++
 tb/tb_reg_file_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
`timescale 1ns/1ps
// reg_file_param
// Parametrised register file for the single-cycle datapath: DEPTH = 2**ADDR_W
// words of DATA_W bits, two combinational read ports, one synchronous write
// port, an optional hardwired zero register, optional write-to-read bypass,
// and a valid/ready dump engine that streams every register to a debug sink.
//
// Ports
//   CLK, RESET              clock, synchronous active-high reset
//   WRITE, INADDRESS, IN    write port (commits on the rising edge)
//   OUT1ADDRESS, OUT1       read port 1 (combinational)
//   OUT2ADDRESS, OUT2       read port 2 (combinational)
//   DUMP_START              one-cycle request to start a dump
//   DUMP_READY              sink accepts the current beat
//   DUMP_VALID, DUMP_ADDR,  current beat
//   DUMP_DATA
//   DUMP_BUSY               dump engine not idle
//
// RD_DELAY / WR_DELAY describe the timing of the behavioural model this block
// replaces. This implementation is zero-delay; the parameters are kept so
// existing instantiations still elaborate.
module reg_file_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b0,
  parameter int unsigned RD_DELAY = 2,
  parameter int unsigned WR_DELAY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              DUMP_START,
  input  logic              DUMP_READY,
  output logic              DUMP_VALID,
  output logic [ADDR_W-1:0] DUMP_ADDR,
  output logic [DATA_W-1:0] DUMP_DATA,
  output logic              DUMP_BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Timing annotations only; nothing to build.
  if ((RD_DELAY > 0) || (WR_DELAY > 0)) begin : g_delay_annotated
  end

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;

  logic wr_drop;
  logic wr_commit;
  logic byp_en;

  // A write to r0 is discarded when r0 is hardwired.
  assign wr_drop   = ZERO_REG && (INADDRESS == '0);
  assign wr_commit = WRITE && !RESET && !wr_drop;
  // Bypass only forwards writes that will actually land in the array.
  assign byp_en    = BYPASS && wr_commit;

  // Array: reset clears every word, otherwise one write per edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      mem[INADDRESS] <= IN;
    end
  end

  // Read ports resolve independently: zero register, then bypass, then array.
  always_comb begin
    OUT1 = mem[OUT1ADDRESS];
    if (ZERO_REG && (OUT1ADDRESS == '0)) begin
      OUT1 = '0;
    end else if (byp_en && (OUT1ADDRESS == INADDRESS)) begin
      OUT1 = IN;
    end
  end

  always_comb begin
    OUT2 = mem[OUT2ADDRESS];
    if (ZERO_REG && (OUT2ADDRESS == '0)) begin
      OUT2 = '0;
    end else if (byp_en && (OUT2ADDRESS == INADDRESS)) begin
      OUT2 = IN;
    end
  end

  // Dump engine: one beat per accepted handshake, DEPTH beats, no restart.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ptr <= '0;
          if (DUMP_START) begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (DUMP_READY) begin
            if (ptr == LAST_ADDR) begin
              state <= S_IDLE;
              ptr   <= '0;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign DUMP_VALID = (state == S_SEND);
  assign DUMP_BUSY  = (state == S_SEND);
  assign DUMP_ADDR  = ptr;

  // Beat data tracks the live array, so a committed write shows up at once.
  always_comb begin
    DUMP_DATA = '0;
    if (state == S_SEND) begin
      if (ZERO_REG && (ptr == '0)) begin
        DUMP_DATA = '0;
      end else begin
        DUMP_DATA = mem[ptr];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
`timescale 1ns/1ps
// tb_reg_file_param
// Directed bench for reg_file_param. Two instances share one stimulus:
// u_plain (ZERO_REG=0, BYPASS=0) and u_zb (ZERO_REG=1, BYPASS=1).
module tb_reg_file_param;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          reset;
  logic          write;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [AW-1:0] rd1_addr;
  logic [AW-1:0] rd2_addr;
  logic          dump_start;
  logic          dump_ready;

  logic [DW-1:0] out1_a, out2_a, ddata_a;
  logic [AW-1:0] daddr_a;
  logic          dvalid_a, dbusy_a;
  logic [DW-1:0] out1_b, out2_b, ddata_b;
  logic [AW-1:0] daddr_b;
  logic          dvalid_b, dbusy_b;

  int n_chk = 0;
  int n_bad = 0;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_plain (
    .CLK(clk), .RESET(reset), .WRITE(write), .INADDRESS(in_addr), .IN(in_data),
    .OUT1ADDRESS(rd1_addr), .OUT2ADDRESS(rd2_addr), .OUT1(out1_a), .OUT2(out2_a),
    .DUMP_START(dump_start), .DUMP_READY(dump_ready), .DUMP_VALID(dvalid_a),
    .DUMP_ADDR(daddr_a), .DUMP_DATA(ddata_a), .DUMP_BUSY(dbusy_a)
  );

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_zb (
    .CLK(clk), .RESET(reset), .WRITE(write), .INADDRESS(in_addr), .IN(in_data),
    .OUT1ADDRESS(rd1_addr), .OUT2ADDRESS(rd2_addr), .OUT1(out1_b), .OUT2(out2_b),
    .DUMP_START(dump_start), .DUMP_READY(dump_ready), .DUMP_VALID(dvalid_b),
    .DUMP_ADDR(daddr_b), .DUMP_DATA(ddata_b), .DUMP_BUSY(dbusy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write   = 1'b1;
    in_addr = a;
    in_data = d;
    tick();
    write   = 1'b0;
  endtask

  int beat;
  int cnt;
  bit r;

  initial begin
    reset = 1'b1; write = 1'b0; in_addr = '0; in_data = '0;
    rd1_addr = '0; rd2_addr = '0; dump_start = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset then readback
    wr(3'd3, 8'hA5);
    rd1_addr = 3'd3; rd2_addr = 3'd3;
    #3;
    chk("pre_reset_r3", 32'(out1_a), 32'h0A5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #3;
    chk("rst_out1", 32'(out1_a), 32'h0);
    chk("rst_out2", 32'(out2_a), 32'h0);
    chk("rst_out1_zb", 32'(out1_b), 32'h0);
    chk("rst_busy", 32'(dbusy_a), 32'h0);
    chk("rst_valid", 32'(dvalid_a), 32'h0);
    chk("rst_daddr", 32'(daddr_a), 32'h0);
    chk("rst_ddata", 32'(ddata_a), 32'h0);

    // Write / read on both ports
    wr(3'd1, 8'h12);
    wr(3'd7, 8'hFE);
    rd1_addr = 3'd1; rd2_addr = 3'd7;
    #3;
    chk("rd_r1", 32'(out1_a), 32'h12);
    chk("rd_r7", 32'(out2_a), 32'hFE);
    chk("rd_r1_zb", 32'(out1_b), 32'h12);
    chk("rd_r7_zb", 32'(out2_b), 32'hFE);

    // Bypass: forwarded pre-edge only in the BYPASS instance
    write = 1'b1; in_addr = 3'd5; in_data = 8'h3C;
    rd1_addr = 3'd5; rd2_addr = 3'd1;
    #3;
    chk("byp_out1_zb", 32'(out1_b), 32'h3C);
    chk("byp_other_port", 32'(out2_b), 32'h12);
    chk("nobyp_old", 32'(out1_a), 32'h00);
    tick();
    write = 1'b0;
    #1;
    chk("nobyp_after", 32'(out1_a), 32'h3C);

    // Zero register: write to r0 dropped and not bypassed
    write = 1'b1; in_addr = 3'd0; in_data = 8'hFF; rd1_addr = 3'd0;
    #3;
    chk("zr_pre_zb", 32'(out1_b), 32'h00);
    tick();
    write = 1'b0;
    #1;
    chk("zr_plain_r0", 32'(out1_a), 32'hFF);
    chk("zr_zb_r0", 32'(out1_b), 32'h00);

    // Dump with READY toggling 1,0,1,...
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(8'h10 + i));
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    beat = 0;
    r = 1'b1;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      dump_ready = r;
      #2;
      chk("dmp_valid", 32'(dvalid_a), 32'h1);
      chk("dmp_addr", 32'(daddr_a), 32'(beat));
      chk("dmp_data", 32'(ddata_a), 32'(8'h10 + beat));
      chk("dmp_data_zb", 32'(ddata_b), (beat == 0) ? 32'h0 : 32'(8'h10 + beat));
      if (r) beat++;
      r = ~r;
      tick();
    end
    chk("dmp_beats", 32'(beat), 32'd8);
    dump_ready = 1'b0;
    #2;
    chk("dmp_done_busy", 32'(dbusy_a), 32'h0);
    chk("dmp_done_valid", 32'(dvalid_a), 32'h0);
    chk("dmp_done_addr", 32'(daddr_a), 32'h0);
    tick();

    // READY held high: BUSY for exactly 8 cycles; a START mid-dump is ignored
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (dbusy_a) cnt++;
      dump_start = (c == 3);
      tick();
    end
    chk("busy_cycles", 32'(cnt), 32'd8);
    chk("busy_end", 32'(dbusy_a), 32'h0);

    // Reset mid-dump, with a simultaneous START that must lose
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick(); tick(); tick();
    chk("mid_addr3", 32'(daddr_a), 32'd3);
    reset = 1'b1;
    dump_start = 1'b1;
    tick();
    reset = 1'b0;
    dump_start = 1'b0;
    rd1_addr = 3'd3; rd2_addr = 3'd7;
    #2;
    chk("mid_valid", 32'(dvalid_a), 32'h0);
    chk("mid_busy", 32'(dbusy_a), 32'h0);
    chk("mid_daddr", 32'(daddr_a), 32'h0);
    chk("mid_r3", 32'(out1_a), 32'h0);
    chk("mid_r7", 32'(out2_a), 32'h0);
    tick();
    chk("mid_still_idle", 32'(dbusy_a), 32'h0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    #2;
    chk("restart_valid", 32'(dvalid_a), 32'h1);
    chk("restart_addr", 32'(daddr_a), 32'h0);
    chk("restart_data", 32'(ddata_a), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
